// File: rtl/uart_periph_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encodings for uart_periph.
// Defining UART_PERIPH_IRQ_EN widens the register window so the IRQEN offset (0x10) is addressable.
package uart_periph_pkg;

`ifdef UART_PERIPH_IRQ_EN
    localparam int BUS_AW = 5;
`else
    localparam int BUS_AW = 4;
`endif

    localparam logic [4:0] REG_TXDATA  = 5'h00;
    localparam logic [4:0] REG_RXDATA  = 5'h04;
    localparam logic [4:0] REG_STATUS  = 5'h08;
    localparam logic [4:0] REG_BAUDDIV = 5'h0C;
    localparam logic [4:0] REG_IRQEN   = 5'h10;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_TX_OVF    = 3;
    localparam int ST_RX_OVF    = 4;
    localparam int ST_FRAME_ERR = 5;

    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push on a full FIFO succeeds only alongside a pop, pop on empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_V);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped full-duplex UART: TX/RX FIFOs, programmable divisor, sticky error flags.
// Optional level interrupt and IRQEN register when UART_PERIPH_IRQ_EN is defined.
module uart_periph
    import uart_periph_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_AW-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    input  logic              bus_wen,
    input  logic              bus_ren,
    output logic [31:0]       bus_rdata,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              irq
);
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(CLK_FREQ / BAUD_RATE);
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic [4:0]       addr_full;
    logic             wr_tx, wr_status, wr_baud, rd_rx_pop;
    logic [DIV_W-1:0] div_reg;
    logic             tx_ovf, rx_ovf, frame_err;
    logic             unused_bits;

    assign addr_full   = 5'(bus_addr);
    assign wr_tx       = bus_wen & (addr_full[4:2] == REG_TXDATA[4:2]);
    assign wr_status   = bus_wen & (addr_full[4:2] == REG_STATUS[4:2]);
    assign wr_baud     = bus_wen & (addr_full[4:2] == REG_BAUDDIV[4:2]);
    assign rd_rx_pop   = bus_ren & (addr_full[4:2] == REG_RXDATA[4:2]);
    assign unused_bits = ^{addr_full[1:0], bus_wdata};

    // ---------------- FIFOs ----------------
    logic       tx_pop, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full, rx_empty;
    logic [7:0] rx_head, rx_shift;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(wr_tx), .wdata(bus_wdata[7:0]), .pop(tx_pop),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift), .pop(rd_rx_pop),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- TX FSM ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [DIV_W-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]       tx_bit, tx_bit_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_bit_done, tx_busy;

    assign tx_bit_done = (tx_cnt == tx_div - ONE);
    assign tx_busy     = (tx_state != TX_IDLE) | ~tx_empty;
    assign uart_tx     = (tx_state == TX_START) ? 1'b0 :
                         (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + ONE;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_START;
                    tx_div_n   = div_reg;
                    tx_shift_n = tx_head;
                end
            end
            TX_START: if (tx_bit_done) begin
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                tx_state_n = TX_DATA;
            end
            TX_DATA: if (tx_bit_done) begin
                tx_cnt_n   = '0;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                tx_bit_n   = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_n = TX_STOP;
            end
            TX_STOP: if (tx_bit_done) begin
                tx_cnt_n = '0;
                // Chain straight into the next start bit so queued frames have no idle gap.
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_START;
                    tx_div_n   = div_reg;
                    tx_shift_n = tx_head;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- RX FSM ----------------
    rx_state_t        rx_state, rx_state_n;
    logic [DIV_W-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift_n;
    logic             rx_meta, rx_sync, rx_sync_d;
    logic             frame_err_set, rx_ovf_set, tx_ovf_set;

    assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;

    always_comb begin
        rx_state_n    = rx_state;
        rx_cnt_n      = rx_cnt + ONE;
        rx_div_n      = rx_div;
        rx_bit_n      = rx_bit;
        rx_shift_n    = rx_shift;
        rx_push       = 1'b0;
        frame_err_set = 1'b0;
        rx_ovf_set    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_sync_d && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_div_n   = div_reg;
                end
            end
            RX_START: if (rx_cnt == (rx_div >> 1) - ONE) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == rx_div - ONE) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_sync, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_cnt == rx_div - ONE) begin
                rx_cnt_n   = '0;
                rx_state_n = RX_IDLE;
                if (!rx_sync) begin
                    frame_err_set = 1'b1;
                end else begin
                    rx_push    = 1'b1;
                    rx_ovf_set = rx_full & ~rd_rx_pop;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- State and registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_div    <= RESET_DIV;
            tx_bit    <= '0;
            tx_shift  <= '0;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_div    <= RESET_DIV;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
            div_reg   <= RESET_DIV;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_div    <= tx_div_n;
            tx_bit    <= tx_bit_n;
            tx_shift  <= tx_shift_n;
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_div    <= rx_div_n;
            rx_bit    <= rx_bit_n;
            rx_shift  <= rx_shift_n;
            rx_meta   <= uart_rx;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
            if (wr_baud)
                div_reg <= (bus_wdata[DIV_W-1:0] < MIN_DIV_V) ? MIN_DIV_V : bus_wdata[DIV_W-1:0];
            // A set in the same cycle as its write-1-to-clear wins.
            tx_ovf    <= (tx_ovf    & ~(wr_status & bus_wdata[ST_TX_OVF]))    | tx_ovf_set;
            rx_ovf    <= (rx_ovf    & ~(wr_status & bus_wdata[ST_RX_OVF]))    | rx_ovf_set;
            frame_err <= (frame_err & ~(wr_status & bus_wdata[ST_FRAME_ERR])) | frame_err_set;
        end
    end

    // ---------------- Interrupt ----------------
`ifdef UART_PERIPH_IRQ_EN
    logic       wr_irqen;
    logic [2:0] irq_en;
    logic       irq_q;

    assign wr_irqen = bus_wen & (addr_full[4:2] == REG_IRQEN[4:2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_irqen) irq_en <= bus_wdata[2:0];
            irq_q <= |(irq_en & {tx_ovf | rx_ovf | frame_err, tx_empty, ~rx_empty});
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ---------------- Read mux ----------------
    logic [31:0] status_word;

    always_comb begin
        status_word               = '0;
        status_word[ST_TX_BUSY]   = tx_busy;
        status_word[ST_TX_FULL]   = tx_full;
        status_word[ST_RX_EMPTY]  = rx_empty;
        status_word[ST_TX_OVF]    = tx_ovf;
        status_word[ST_RX_OVF]    = rx_ovf;
        status_word[ST_FRAME_ERR] = frame_err;
    end

    always_comb begin
        bus_rdata = '0;
        case (addr_full[4:2])
            REG_RXDATA[4:2]:  bus_rdata = {23'b0, rx_empty, rx_empty ? 8'h00 : rx_head};
            REG_STATUS[4:2]:  bus_rdata = status_word;
            REG_BAUDDIV[4:2]: bus_rdata = 32'(div_reg);
`ifdef UART_PERIPH_IRQ_EN
            REG_IRQEN[4:2]:   bus_rdata = {29'b0, irq_en};
`endif
            default:          bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: registers, TX framing, RX sampling and errors, loopback.
// Build with UART_PERIPH_IRQ_EN defined to also exercise IRQEN and the irq output.
module tb_uart_periph;
    import uart_periph_pkg::*;

    localparam int DIV = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BUS_AW-1:0] bus_addr = '0;
    logic [31:0]       bus_wdata = '0;
    logic              bus_wen = 1'b0;
    logic              bus_ren = 1'b0;
    logic [31:0]       bus_rdata;
    logic              rx_drv = 1'b1;
    logic              loop_en = 1'b0;
    logic              uart_rx_w;
    logic              uart_tx;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];       // expected RXDATA words
    logic [0:0] tx_bit_q[$];    // expected line level per TX bit period

    assign uart_rx_w = loop_en ? uart_tx : rx_drv;

    uart_periph dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata),
        .uart_rx(uart_rx_w), .uart_tx(uart_tx), .irq(irq)
    );

    // ---------------- Clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- Drivers (entered and left on a falling edge) ----------------
    task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
        bus_addr  = BUS_AW'(off);
        bus_wdata = data;
        bus_wen   = 1'b1;
        @(negedge clk);
        bus_wen   = 1'b0;
    endtask

    task automatic bus_peek(input logic [4:0] off, output logic [31:0] data);
        bus_addr = BUS_AW'(off);
        #1;
        data = bus_rdata;
    endtask

    task automatic bus_pop(output logic [31:0] data);
        bus_addr = BUS_AW'(REG_RXDATA);
        bus_ren  = 1'b1;
        #1;
        data = bus_rdata;
        @(negedge clk);
        bus_ren = 1'b0;
    endtask

    task automatic tx_send(input logic [7:0] b);
        tx_bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_bit_q.push_back(b[i]);
        tx_bit_q.push_back(1'b1);
        bus_write(REG_TXDATA, {24'b0, b});
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (DIV) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic wait_tx_idle(input int limit);
        logic [31:0] s;
        int k = 0;
        bus_peek(REG_STATUS, s);
        while (s[ST_TX_BUSY] && k < limit) begin
            @(negedge clk);
            bus_peek(REG_STATUS, s);
            k++;
        end
        n_checks++;
        if (s[ST_TX_BUSY] !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_idle_wait: tx_busy=%b after %0d cycles, need 0", s[ST_TX_BUSY], limit);
        end
    endtask

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        logic [31:0] s;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b need 1", uart_tx); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b need 0", irq); end
        rst = 1'b0;
        @(negedge clk);
        bus_peek(REG_BAUDDIV, s);
        n_checks++;
        if (s !== 32'd434) begin n_fail++; $display("FAIL reset_bauddiv: got %0d need 434", s); end
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s !== 32'h04) begin n_fail++; $display("FAIL reset_status: got %h need 00000004", s); end
        bus_peek(REG_TXDATA, s);
        n_checks++;
        if (s !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h need 0", s); end
    endtask

    task automatic test_bauddiv();
        logic [31:0] s;
        logic [31:0] wr_vals [4]  = '{32'd0, 32'd3, 32'd4, 32'd5};
        logic [31:0] exp_vals [4] = '{32'd4, 32'd4, 32'd4, 32'd5};
        for (int i = 0; i < 4; i++) begin
            bus_write(REG_BAUDDIV, wr_vals[i]);
            bus_peek(REG_BAUDDIV, s);
            n_checks++;
            if (s !== exp_vals[i]) begin
                n_fail++;
                $display("FAIL bauddiv_clamp: wrote %0d got %0d need %0d", wr_vals[i], s, exp_vals[i]);
            end
        end
        bus_write(REG_BAUDDIV, DIV);
    endtask

    task automatic test_tx_frames();
        logic [31:0] s;
        logic [0:0]  eb;
        int k = 0;
        tx_send(8'h55);
        tx_send(8'hA3);
        while (uart_tx !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL tx_start: line=%b need 0", uart_tx); end
        repeat (DIV / 2) @(negedge clk);
        for (int b = 0; b < 20; b++) begin
            eb = tx_bit_q.pop_front();
            n_checks++;
            if (uart_tx !== eb[0]) begin
                n_fail++;
                $display("FAIL tx_bit: bit %0d line=%b need %b", b, uart_tx, eb[0]);
            end
            if (b != 19) repeat (DIV) @(negedge clk);
        end
        // Middle of the last stop bit: busy holds for three more cycles, then drops.
        repeat (3) @(negedge clk);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s[ST_TX_BUSY] !== 1'b1) begin n_fail++; $display("FAIL tx_busy_end: got %b need 1", s[ST_TX_BUSY]); end
        @(negedge clk);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s[ST_TX_BUSY] !== 1'b0) begin n_fail++; $display("FAIL tx_busy_clear: got %b need 0", s[ST_TX_BUSY]); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] s;
        // The first byte moves into the shifter one cycle after landing, so 17 writes fill 16 slots.
        for (int i = 0; i < 17; i++) bus_write(REG_TXDATA, 32'(i));
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s[ST_TX_FULL] !== 1'b1) begin n_fail++; $display("FAIL tx_full: got %b need 1", s[ST_TX_FULL]); end
        n_checks++;
        if (s[ST_TX_OVF] !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_early: got %b need 0", s[ST_TX_OVF]); end
        bus_write(REG_TXDATA, 32'hEE);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s[ST_TX_OVF] !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_set: got %b need 1", s[ST_TX_OVF]); end
        bus_write(REG_STATUS, 32'h08);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s[ST_TX_OVF] !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_clear: got %b need 0", s[ST_TX_OVF]); end
        wait_tx_idle(1500);
    endtask

    task automatic test_rx_byte();
        logic [31:0] s;
        logic [8:0]  e;
        exp_q.push_back(9'h0C4);
        drive_rx_frame(8'hC4, 1'b1);
        repeat (4) @(negedge clk);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s !== 32'h00) begin n_fail++; $display("FAIL rx_status: got %h need 00000000", s); end
        bus_pop(s);
        e = exp_q.pop_front();
        n_checks++;
        if (s !== {23'b0, e}) begin n_fail++; $display("FAIL rx_data: got %h need %h", s, {23'b0, e}); end
        bus_pop(s);
        n_checks++;
        if (s !== 32'h100) begin n_fail++; $display("FAIL rx_empty_read: got %h need 00000100", s); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] s;
        drive_rx_frame(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s !== 32'h24) begin n_fail++; $display("FAIL frame_err: status %h need 00000024", s); end
        bus_write(REG_STATUS, 32'h20);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s !== 32'h04) begin n_fail++; $display("FAIL frame_err_clear: status %h need 00000004", s); end
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s !== 32'h04) begin n_fail++; $display("FAIL rx_glitch: status %h need 00000004", s); end
    endtask

    task automatic test_loopback();
        logic [31:0] s;
        logic [8:0]  e;
        logic [7:0]  bytes [3] = '{8'h00, 8'hFF, 8'h5A};
        loop_en = 1'b1;
        @(negedge clk);
`ifdef UART_PERIPH_IRQ_EN
        bus_write(REG_IRQEN, 32'h1);
        bus_peek(REG_IRQEN, s);
        n_checks++;
        if (s !== 32'h1) begin n_fail++; $display("FAIL irqen_read: got %h need 00000001", s); end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b need 0", irq); end
`endif
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, bytes[i]});
            bus_write(REG_TXDATA, {24'b0, bytes[i]});
        end
        wait_tx_idle(400);
        repeat (20) @(negedge clk);
`ifdef UART_PERIPH_IRQ_EN
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx_pending: got %b need 1", irq); end
`else
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied: got %b need 0", irq); end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus_pop(s);
            n_checks++;
            if (s !== {23'b0, e}) begin n_fail++; $display("FAIL loop_data: got %h need %h", s, {23'b0, e}); end
        end
`ifdef UART_PERIPH_IRQ_EN
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b need 1", irq); end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b need 0", irq); end
`endif
        bus_peek(REG_RXDATA, s);
        n_checks++;
        if (s !== 32'h100) begin n_fail++; $display("FAIL loop_drained: got %h need 00000100", s); end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] s;
        bus_write(REG_TXDATA, 32'h00);
        repeat (20) @(negedge clk);
        n_checks++;
        if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_frame_low: got %b need 0", uart_tx); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL mid_frame_reset: got %b need 1", uart_tx); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_peek(REG_STATUS, s);
        n_checks++;
        if (s !== 32'h04) begin n_fail++; $display("FAIL post_reset_status: got %h need 00000004", s); end
        bus_peek(REG_BAUDDIV, s);
        n_checks++;
        if (s !== 32'd434) begin n_fail++; $display("FAIL post_reset_div: got %0d need 434", s); end
    endtask

    // ---------------- Sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_bauddiv();
        test_tx_frames();
        test_tx_overflow();
        test_rx_byte();
        test_rx_errors();
        test_loopback();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
